// File: rtl/interrupt_ack_sequencer_if.sv
// ---------------------------------------------------------------------------
// interrupt_ack_sequencer_if
//   Groups the resolver, CPU acknowledge and command-write signals of the
//   interrupt acknowledge sequencer into one bundle.
//
//   Resolver side : INT_request, serviced_interrupt_index, zeroLevelPriorityBit
//   CPU side      : INTA_n (active-low, already synchronous to clk)
//   Config/cmd    : ICW2_vector, AEOI, OCW2, OCW2_write
//   Outputs       : INT, INT_requestAck, freezing, ISR_reg, resetedISR_index,
//                   ISR_reset_valid, data_out, data_en
//
//   modport slave  - seen by the sequencer (inputs in, status/vector out)
//   modport master - seen by the environment that drives the sequencer
// ---------------------------------------------------------------------------
interface interrupt_ack_sequencer_if;
  logic       INT_request;
  logic [2:0] serviced_interrupt_index;
  logic [2:0] zeroLevelPriorityBit;
  logic       INTA_n;
  logic [4:0] ICW2_vector;
  logic       AEOI;
  logic [7:0] OCW2;
  logic       OCW2_write;

  logic       INT;
  logic       INT_requestAck;
  logic       freezing;
  logic [7:0] ISR_reg;
  logic [2:0] resetedISR_index;
  logic       ISR_reset_valid;
  logic [7:0] data_out;
  logic       data_en;

  modport slave (
    input  INT_request, serviced_interrupt_index, zeroLevelPriorityBit,
    input  INTA_n, ICW2_vector, AEOI, OCW2, OCW2_write,
    output INT, INT_requestAck, freezing, ISR_reg, resetedISR_index,
    output ISR_reset_valid, data_out, data_en
  );

  modport master (
    output INT_request, serviced_interrupt_index, zeroLevelPriorityBit,
    output INTA_n, ICW2_vector, AEOI, OCW2, OCW2_write,
    input  INT, INT_requestAck, freezing, ISR_reg, resetedISR_index,
    input  ISR_reset_valid, data_out, data_en
  );
endinterface

// File: rtl/interrupt_ack_sequencer.sv
// ---------------------------------------------------------------------------
// interrupt_ack_sequencer
//   8259-style interrupt acknowledge sequencer. Raises INT on a resolver
//   request, walks the two-pulse INTA handshake, sets the in-service bit on
//   the first INTA, drives the vector byte during the second INTA and handles
//   automatic EOI as well as specific / non-specific EOI commands from OCW2.
//
//   Ports:
//     clk     - system clock, all state changes on the rising edge
//     reset_n - asynchronous active-low reset
//     bus     - interrupt_ack_sequencer_if.slave (see interface header)
// ---------------------------------------------------------------------------
module interrupt_ack_sequencer (
  input  logic                       clk,
  input  logic                       reset_n,
  interrupt_ack_sequencer_if.slave   bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] INT_PEND = 3'd1;
  localparam logic [2:0] ACK1     = 3'd2;
  localparam logic [2:0] GAP      = 3'd3;
  localparam logic [2:0] ACK2     = 3'd4;

  logic [2:0] state_q, state_d;
  logic       inta_n_q;
  logic       int_q, int_d;
  logic       ack_q, ack_d;
  logic       freeze_q, freeze_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] rstIdx_q, rstIdx_d;
  logic       rstValid_q, rstValid_d;
  logic [7:0] dout_q, dout_d;
  logic       den_q, den_d;

  logic       intaFall, intaRise;
  logic       aeoiClr;
  logic [7:0] setMask, clrMask;
  logic       nsFound;
  logic [2:0] nsIdx;
  logic [2:0] cmd;

  // INTA edges are judged against the previous-cycle copy of INTA_n
  assign intaFall = inta_n_q & ~bus.INTA_n;
  assign intaRise = ~inta_n_q & bus.INTA_n;
  assign cmd      = bus.OCW2[7:5];

  // Non-specific EOI target: first set ISR bit scanning upward from the
  // current highest-priority level, wrapping 7 -> 0. Scanning offsets from
  // high to low lets the smallest offset overwrite the result last.
  always_comb begin
    logic [2:0] pos;
    nsFound = 1'b0;
    nsIdx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      pos = bus.zeroLevelPriorityBit + 3'(i);
      if (isr_q[pos]) begin
        nsFound = 1'b1;
        nsIdx   = pos;
      end
    end
  end

  // Handshake FSM plus ISR update. The clear mask is applied before the
  // set mask so a first-INTA set wins over an EOI to the same bit, and an
  // AEOI clear pre-empts any OCW2 EOI arriving in the same cycle.
  always_comb begin
    state_d    = state_q;
    int_d      = int_q;
    ack_d      = ack_q;
    freeze_d   = freeze_q;
    idx_d      = idx_q;
    rstIdx_d   = rstIdx_q;
    rstValid_d = 1'b0;
    dout_d     = dout_q;
    den_d      = den_q;
    aeoiClr    = 1'b0;
    setMask    = 8'h00;
    clrMask    = 8'h00;

    case (state_q)
      IDLE: begin
        if (bus.INT_request) begin
          state_d = INT_PEND;
          int_d   = 1'b1;
        end
      end
      INT_PEND: begin
        if (intaFall) begin
          state_d  = ACK1;
          freeze_d = 1'b1;
          setMask  = 8'b1 << bus.serviced_interrupt_index;
          idx_d    = bus.serviced_interrupt_index;
          ack_d    = ~ack_q;
        end
      end
      ACK1: begin
        if (intaRise) begin
          state_d = GAP;
          int_d   = 1'b0;
        end
      end
      GAP: begin
        if (intaFall) begin
          state_d = ACK2;
          dout_d  = {bus.ICW2_vector, idx_q};
          den_d   = 1'b1;
        end
      end
      ACK2: begin
        if (intaRise) begin
          state_d  = IDLE;
          den_d    = 1'b0;
          freeze_d = 1'b0;
          aeoiClr  = bus.AEOI;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (aeoiClr) begin
      clrMask    = 8'b1 << idx_q;
      rstIdx_d   = idx_q;
      rstValid_d = 1'b1;
    end else if (bus.OCW2_write) begin
      if ((cmd == 3'b001 || cmd == 3'b101) && nsFound) begin
        clrMask    = 8'b1 << nsIdx;
        rstIdx_d   = nsIdx;
        rstValid_d = 1'b1;
      end else if ((cmd == 3'b011 || cmd == 3'b111) && isr_q[bus.OCW2[2:0]]) begin
        clrMask    = 8'b1 << bus.OCW2[2:0];
        rstIdx_d   = bus.OCW2[2:0];
        rstValid_d = 1'b1;
      end
    end

    isr_d = (isr_q & ~clrMask) | setMask;
  end

  // State registers; reset abandons any sequence in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      inta_n_q   <= 1'b1;
      int_q      <= 1'b0;
      ack_q      <= 1'b0;
      freeze_q   <= 1'b0;
      isr_q      <= 8'h00;
      idx_q      <= 3'd0;
      rstIdx_q   <= 3'd0;
      rstValid_q <= 1'b0;
      dout_q     <= 8'h00;
      den_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inta_n_q   <= bus.INTA_n;
      int_q      <= int_d;
      ack_q      <= ack_d;
      freeze_q   <= freeze_d;
      isr_q      <= isr_d;
      idx_q      <= idx_d;
      rstIdx_q   <= rstIdx_d;
      rstValid_q <= rstValid_d;
      dout_q     <= dout_d;
      den_q      <= den_d;
    end
  end

  assign bus.INT              = int_q;
  assign bus.INT_requestAck   = ack_q;
  assign bus.freezing         = freeze_q;
  assign bus.ISR_reg          = isr_q;
  assign bus.resetedISR_index = rstIdx_q;
  assign bus.ISR_reset_valid  = rstValid_q;
  assign bus.data_out         = dout_q;
  assign bus.data_en          = den_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// ---------------------------------------------------------------------------
// tb_interrupt_ack_sequencer
//   Directed bench for interrupt_ack_sequencer. Stimulus pushes the expected
//   EOI pulses and vector bytes into queues; two monitors pop and compare
//   whenever the DUT presents ISR_reset_valid or a rising data_en.
// ---------------------------------------------------------------------------
module tb_interrupt_ack_sequencer;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] isr;
  } pulseExp_t;

  logic clk;
  logic reset_n;
  interrupt_ack_sequencer_if bus ();

  interrupt_ack_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int testsRun = 0;
  int testsFailed = 0;
  pulseExp_t pulseQ[$];
  logic [7:0] dataQ[$];
  logic expAck = 1'b0;
  logic prevDen = 1'b0;

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectPulse(input logic [2:0] idx, input logic [7:0] isr);
    pulseExp_t p;
    p.idx = idx;
    p.isr = isr;
    pulseQ.push_back(p);
  endtask

  // EOI-pulse monitor: every ISR_reset_valid must match a queued expectation
  initial begin
    pulseExp_t p;
    forever begin
      @(negedge clk);
      if (bus.ISR_reset_valid === 1'b1) begin
        if (pulseQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_eoi_pulse: got index %0d expected no pulse", bus.resetedISR_index);
        end else begin
          p = pulseQ.pop_front();
          checkOutput("eoi_index", {5'b0, bus.resetedISR_index}, {5'b0, p.idx});
          checkOutput("eoi_isr", bus.ISR_reg, p.isr);
        end
      end
    end
  end

  // Vector monitor: each rising data_en must match a queued vector byte
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (bus.data_en === 1'b1 && !prevDen) begin
        if (dataQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_vector: got %h expected no data_en", bus.data_out);
        end else begin
          d = dataQ.pop_front();
          checkOutput("vector", bus.data_out, d);
        end
      end
      prevDen = (bus.data_en === 1'b1);
    end
  end

  task automatic writeOcw(input logic [7:0] ocw, input logic [2:0] zl);
    bus.zeroLevelPriorityBit = zl;
    bus.OCW2 = ocw;
    bus.OCW2_write = 1'b1;
    tick();
    bus.OCW2_write = 1'b0;
    tick();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_INT"}, {7'b0, bus.INT}, 8'h00);
    checkOutput({tag, "_ack"}, {7'b0, bus.INT_requestAck}, 8'h00);
    checkOutput({tag, "_freezing"}, {7'b0, bus.freezing}, 8'h00);
    checkOutput({tag, "_isr"}, bus.ISR_reg, 8'h00);
    checkOutput({tag, "_rstidx"}, {5'b0, bus.resetedISR_index}, 8'h00);
    checkOutput({tag, "_rstvalid"}, {7'b0, bus.ISR_reset_valid}, 8'h00);
    checkOutput({tag, "_dout"}, bus.data_out, 8'h00);
    checkOutput({tag, "_den"}, {7'b0, bus.data_en}, 8'h00);
  endtask

  // Full request + two-INTA sequence with optional OCW2 writes aligned to the
  // first INTA falling edge or the second INTA rising edge.
  task automatic applyStimulus(input logic [2:0] idx, input logic aeoi,
                               input logic [7:0] expIsrMid, input logic [7:0] expIsrEnd,
                               input logic [7:0] expData,
                               input logic [7:0] ocwFirst, input logic ocwFirstWr,
                               input logic [7:0] ocwLast, input logic ocwLastWr);
    dataQ.push_back(expData);
    bus.serviced_interrupt_index = idx;
    bus.AEOI = aeoi;
    bus.INT_request = 1'b1;
    tick();
    bus.INT_request = 1'b0;
    checkOutput("int_pending", {7'b0, bus.INT}, 8'h01);
    tick();
    bus.INTA_n = 1'b0;
    if (ocwFirstWr) begin
      bus.OCW2 = ocwFirst;
      bus.OCW2_write = 1'b1;
    end
    tick();
    bus.OCW2_write = 1'b0;
    expAck = ~expAck;
    checkOutput("isr_first_inta", bus.ISR_reg, expIsrMid);
    checkOutput("ack_toggle", {7'b0, bus.INT_requestAck}, {7'b0, expAck});
    checkOutput("freezing_on", {7'b0, bus.freezing}, 8'h01);
    checkOutput("int_in_ack1", {7'b0, bus.INT}, 8'h01);
    bus.INT_request = 1'b1;
    tick();
    bus.INT_request = 1'b0;
    bus.INTA_n = 1'b1;
    tick();
    checkOutput("int_gap", {7'b0, bus.INT}, 8'h00);
    checkOutput("den_gap", {7'b0, bus.data_en}, 8'h00);
    tick();
    bus.INTA_n = 1'b0;
    tick();
    checkOutput("den_ack2", {7'b0, bus.data_en}, 8'h01);
    tick();
    bus.INTA_n = 1'b1;
    if (ocwLastWr) begin
      bus.OCW2 = ocwLast;
      bus.OCW2_write = 1'b1;
    end
    tick();
    bus.OCW2_write = 1'b0;
    checkOutput("den_end", {7'b0, bus.data_en}, 8'h00);
    checkOutput("freezing_off", {7'b0, bus.freezing}, 8'h00);
    checkOutput("isr_end", bus.ISR_reg, expIsrEnd);
    tick();
    tick();
    checkOutput("int_idle", {7'b0, bus.INT}, 8'h00);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    testsRun++;
    testsFailed++;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    reset_n = 1'b0;
    bus.INT_request = 1'b0;
    bus.serviced_interrupt_index = 3'd0;
    bus.zeroLevelPriorityBit = 3'd0;
    bus.INTA_n = 1'b1;
    bus.ICW2_vector = 5'b01000;
    bus.AEOI = 1'b0;
    bus.OCW2 = 8'h00;
    bus.OCW2_write = 1'b0;
    repeat (3) tick();
    checkResetValues("reset");
    reset_n = 1'b1;
    tick();

    // Basic sequence, index 3, no AEOI
    applyStimulus(3'd3, 1'b0, 8'h08, 8'h08, 8'h43, 8'h00, 1'b0, 8'h00, 1'b0);

    // AEOI on index 5
    expectPulse(3'd5, 8'h08);
    applyStimulus(3'd5, 1'b1, 8'h28, 8'h08, 8'h45, 8'h00, 1'b0, 8'h00, 1'b0);

    // Specific EOI empties the ISR, then build ISR = 8'h81
    expectPulse(3'd3, 8'h00);
    writeOcw(8'h63, 3'd0);
    checkOutput("isr_after_seoi3", bus.ISR_reg, 8'h00);
    applyStimulus(3'd7, 1'b0, 8'h80, 8'h80, 8'h47, 8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(3'd0, 1'b0, 8'h81, 8'h81, 8'h40, 8'h00, 1'b0, 8'h00, 1'b0);

    // Non-specific EOI from level 1 finds bit 7 before wrapping to bit 0
    expectPulse(3'd7, 8'h01);
    writeOcw(8'h20, 3'd1);
    checkOutput("isr_nseoi_81", bus.ISR_reg, 8'h01);

    // Specific EOI to a clear bit and an unrelated command: no change
    writeOcw(8'h62, 3'd1);
    checkOutput("isr_seoi_clear_bit", bus.ISR_reg, 8'h01);
    writeOcw(8'h40, 3'd1);
    checkOutput("isr_other_cmd", bus.ISR_reg, 8'h01);
    expectPulse(3'd0, 8'h00);
    writeOcw(8'h60, 3'd1);
    writeOcw(8'h20, 3'd0);
    checkOutput("isr_nseoi_empty", bus.ISR_reg, 8'h00);

    // ISR = 8'h04 then specific EOI 2
    applyStimulus(3'd2, 1'b0, 8'h04, 8'h04, 8'h42, 8'h00, 1'b0, 8'h00, 1'b0);
    expectPulse(3'd2, 8'h00);
    writeOcw(8'h62, 3'd0);
    checkOutput("isr_seoi2", bus.ISR_reg, 8'h00);

    // Wrap-around scan: level 7 -> 0 -> 1 picks bit 1; then 101 form from level 2
    applyStimulus(3'd1, 1'b0, 8'h02, 8'h02, 8'h41, 8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(3'd6, 1'b0, 8'h42, 8'h42, 8'h46, 8'h00, 1'b0, 8'h00, 1'b0);
    expectPulse(3'd1, 8'h40);
    writeOcw(8'h20, 3'd7);
    checkOutput("isr_nseoi_wrap", bus.ISR_reg, 8'h40);
    expectPulse(3'd6, 8'h00);
    writeOcw(8'hA0, 3'd2);
    checkOutput("isr_nseoi_a0", bus.ISR_reg, 8'h00);

    // EOI and first-INTA set on the same bit: set wins
    applyStimulus(3'd4, 1'b0, 8'h10, 8'h10, 8'h44, 8'h00, 1'b0, 8'h00, 1'b0);
    expectPulse(3'd4, 8'h10);
    applyStimulus(3'd4, 1'b0, 8'h10, 8'h10, 8'h44, 8'h64, 1'b1, 8'h00, 1'b0);

    // AEOI and OCW2 EOI in the same cycle: only the AEOI happens
    expectPulse(3'd6, 8'h10);
    applyStimulus(3'd6, 1'b1, 8'h50, 8'h10, 8'h46, 8'h00, 1'b0, 8'h64, 1'b1);
    bus.AEOI = 1'b0;
    expectPulse(3'd4, 8'h00);
    writeOcw(8'hE4, 3'd0);
    checkOutput("isr_seoi_e4", bus.ISR_reg, 8'h00);

    // INTA pulses in IDLE are ignored
    bus.INTA_n = 1'b0;
    repeat (2) tick();
    bus.INTA_n = 1'b1;
    repeat (2) tick();
    checkOutput("idle_inta_isr", bus.ISR_reg, 8'h00);
    checkOutput("idle_inta_den", {7'b0, bus.data_en}, 8'h00);

    // Reset in GAP abandons the sequence
    bus.serviced_interrupt_index = 3'd1;
    bus.AEOI = 1'b1;
    bus.INT_request = 1'b1;
    tick();
    bus.INT_request = 1'b0;
    tick();
    bus.INTA_n = 1'b0;
    tick();
    bus.INTA_n = 1'b1;
    tick();
    checkOutput("pre_reset_isr", bus.ISR_reg, 8'h02);
    #2;
    reset_n = 1'b0;
    #1;
    checkResetValues("gap_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    expAck = 1'b0;
    tick();
    bus.INTA_n = 1'b0;
    repeat (2) tick();
    bus.INTA_n = 1'b1;
    repeat (2) tick();
    checkOutput("post_reset_inta_isr", bus.ISR_reg, 8'h00);
    checkOutput("post_reset_inta_den", {7'b0, bus.data_en}, 8'h00);
    checkOutput("post_reset_inta_frz", {7'b0, bus.freezing}, 8'h00);
    bus.AEOI = 1'b0;
    applyStimulus(3'd3, 1'b0, 8'h08, 8'h08, 8'h43, 8'h00, 1'b0, 8'h00, 1'b0);

    repeat (4) tick();
    checkOutput("pulse_queue_empty", 8'(pulseQ.size()), 8'h00);
    checkOutput("data_queue_empty", 8'(dataQ.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
